dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the pipelined processor (load/store in M stage) and the VGA snake-board reader.
- Processor has default priority. VGA reads fill idle memory cycles. A starvation guard forces a VGA slot after a bounded wait and stalls the processor for that one cycle.
- Sits between the processor's dmem port, the VGA fetch logic and the dmem macro (synchronous read, 1-cycle latency).

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_arbiter_starve_counter.sv | 43 ++++
 rtl/dmem_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: VGA read FSM encoding and
// default dmem geometry.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 32;
    localparam int STARVE_CNT_W = 8;

    typedef enum logic [1:0] {
        V_IDLE = 2'd0,
        V_WAIT = 2'd1,
        V_DATA = 2'd2
    } vga_state_e;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating, clearable up-counter that flags when a pending VGA request has
// waited LIMIT ungranted cycles.
module dmem_arbiter_starve_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {STARVE_CNT_W{1'b0}};
        end else if (inc && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + STARVE_CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= {STARVE_CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: the processor has priority, VGA reads fill idle
// cycles, and a starvation guard forces one VGA slot after a bounded wait.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [DATA_W-1:0] proc_wdata,
    input  logic              proc_wren,
    input  logic              proc_rden,
    output logic              proc_stall,
    output logic [DATA_W-1:0] proc_q,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    vga_state_e state_q;
    vga_state_e state_d;

    logic proc_acc_s;
    logic force_s;
    logic pending_s;
    logic grant_s;
    logic cancel_s;

    assign proc_acc_s = proc_wren | proc_rden;

    // A request counts as pending in V_IDLE (zero-wait path) and in V_WAIT;
    // reset gates it so nothing is granted while reset is held.
    assign pending_s = reset && vga_req && ((state_q == V_IDLE) || (state_q == V_WAIT));
    assign grant_s   = pending_s && (force_s || !proc_acc_s);
    assign cancel_s  = reset && (state_q == V_WAIT) && !vga_req;

    // Every ungranted pending cycle is counted, so a request raised at cycle N
    // is forced no later than N+STARVE_LIMIT.
    dmem_arbiter_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clock   (clock),
        .reset   (reset),
        .inc     (pending_s && !grant_s),
        .clr     (grant_s || cancel_s),
        .at_limit(force_s)
    );

    // VGA FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= V_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // VGA FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            V_IDLE: begin
                if (vga_req) begin
                    state_d = grant_s ? V_DATA : V_WAIT;
                end else begin
                    state_d = V_IDLE;
                end
            end
            V_WAIT: begin
                if (!vga_req) begin
                    state_d = V_IDLE;
                end else if (grant_s) begin
                    state_d = V_DATA;
                end else begin
                    state_d = V_WAIT;
                end
            end
            V_DATA:  state_d = V_IDLE;
            default: state_d = V_IDLE;
        endcase
    end

    // Grant mux and status outputs.
    always_comb begin
        mem_wdata  = proc_wdata;
        vga_rvalid = (state_q == V_DATA);
        if (grant_s) begin
            mem_addr   = vga_addr;
            mem_wren   = 1'b0;
            proc_stall = proc_acc_s;
        end else begin
            mem_addr   = proc_addr;
            mem_wren   = reset && proc_wren;
            proc_stall = 1'b0;
        end
    end

    assign proc_q    = mem_q;
    assign vga_rdata = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural single-port dmem and
// a scoreboard of expected VGA read data.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] proc_addr;
    logic [31:0] proc_wdata;
    logic        proc_wren;
    logic        proc_rden;
    logic        proc_stall;
    logic [31:0] proc_q;
    logic        vga_req;
    logic [11:0] vga_addr;
    logic        vga_rvalid;
    logic [31:0] vga_rdata;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wren;
    logic [31:0] mem_q;

    logic [31:0] mem [0:4095];
    logic [31:0] exp_vga [$];
    logic [31:0] exp_ld  [$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_rvalid = 0;

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIMIT(8)) dut (
        .clock(clock), .reset(reset),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata),
        .proc_wren(proc_wren), .proc_rden(proc_rden),
        .proc_stall(proc_stall), .proc_q(proc_q),
        .vga_req(vga_req), .vga_addr(vga_addr),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    // Synchronous-read single-port memory model (read returns pre-write data).
    always @(posedge clock) begin
        mem_q <= mem[mem_addr];
        if (mem_wren === 1'b1) mem[mem_addr] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every rvalid pulse pops one expected VGA word.
    always @(negedge clock) begin
        if (vga_rvalid === 1'b1) begin
            n_rvalid++;
            if (exp_vga.size() == 0) begin
                check_eq("vga_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                check_eq("vga_rdata", vga_rdata, exp_vga.pop_front());
            end
        end
    end

    // Processor busy every cycle with a VGA request held; forced slot on cycle 9.
    task automatic starve_run(input logic st, input logic [11:0] paddr,
                              input logic [11:0] vaddr, input logic [31:0] vexp);
        proc_wren = st; proc_rden = !st; proc_addr = paddr; proc_wdata = 32'd7;
        vga_req = 1'b1; vga_addr = vaddr;
        exp_vga.push_back(vexp);
        for (int i = 1; i <= 8; i++) begin
            #3;
            check_eq("starve_proc_addr", {20'd0, mem_addr}, {20'd0, paddr});
            check_eq("starve_proc_wren", {31'd0, mem_wren}, {31'd0, st});
            check_eq("starve_no_stall", {31'd0, proc_stall}, 32'd0);
            cyc();
        end
        #3;
        check_eq("forced_addr", {20'd0, mem_addr}, {20'd0, vaddr});
        check_eq("forced_wren", {31'd0, mem_wren}, 32'd0);
        check_eq("forced_stall", {31'd0, proc_stall}, 32'd1);
        cyc();
        vga_req = 1'b0;
        #3;
        check_eq("after_force_rvalid", {31'd0, vga_rvalid}, 32'd1);
        check_eq("after_force_wren", {31'd0, mem_wren}, {31'd0, st});
        check_eq("after_force_addr", {20'd0, mem_addr}, {20'd0, paddr});
        check_eq("after_force_stall", {31'd0, proc_stall}, 32'd0);
        cyc();
        proc_wren = 1'b0; proc_rden = 1'b0;
    endtask

    initial begin
        int vidx;
        int lidx;
        logic ld_prev;
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        mem[100] = 32'h0000_00A5;
        mem[200] = 32'h0000_0200;
        mem[300] = 32'h0000_0300;
        reset = 1'b0; proc_addr = 12'd0; proc_wdata = 32'd0;
        proc_wren = 1'b1; proc_rden = 1'b0; vga_req = 1'b1; vga_addr = 12'd100;
        cyc();
        #3;
        check_eq("reset_wren", {31'd0, mem_wren}, 32'd0);
        check_eq("reset_stall", {31'd0, proc_stall}, 32'd0);
        check_eq("reset_rvalid", {31'd0, vga_rvalid}, 32'd0);
        cyc();
        proc_wren = 1'b0; vga_req = 1'b0;
        reset = 1'b1;
        cyc();

        // Zero-wait VGA read with an idle processor.
        vga_req = 1'b1; vga_addr = 12'd100;
        exp_vga.push_back(32'h0000_00A5);
        #3;
        check_eq("idle_grant_addr", {20'd0, mem_addr}, 32'd100);
        check_eq("idle_grant_stall", {31'd0, proc_stall}, 32'd0);
        cyc();
        vga_req = 1'b0;
        #3;
        check_eq("idle_rvalid", {31'd0, vga_rvalid}, 32'd1);
        cyc();
        #3;
        check_eq("idle_rvalid_pulse", {31'd0, vga_rvalid}, 32'd0);
        cyc();

        // Starvation guard with back-to-back stores.
        starve_run(1'b1, 12'd5, 12'd200, 32'h0000_0200);
        cyc();
        check_eq("store_retry_mem5", mem[5], 32'd7);

        // Write-then-read ordering.
        proc_wren = 1'b1; proc_addr = 12'd20; proc_wdata = 32'd42;
        cyc();
        proc_wren = 1'b0; vga_req = 1'b1; vga_addr = 12'd20;
        exp_vga.push_back(32'd42);
        #3;
        check_eq("wr_rd_grant_addr", {20'd0, mem_addr}, 32'd20);
        cyc();
        vga_req = 1'b0;
        #3;
        check_eq("wr_rd_rvalid", {31'd0, vga_rvalid}, 32'd1);
        cyc();

        // Cancelled request: counter must restart from zero.
        proc_rden = 1'b1; proc_addr = 12'd3; vga_req = 1'b1; vga_addr = 12'd300;
        for (int i = 0; i < 3; i++) begin
            #3;
            check_eq("cancel_wait_stall", {31'd0, proc_stall}, 32'd0);
            check_eq("cancel_wait_rvalid", {31'd0, vga_rvalid}, 32'd0);
            cyc();
        end
        vga_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            check_eq("cancel_after_stall", {31'd0, proc_stall}, 32'd0);
            check_eq("cancel_after_rvalid", {31'd0, vga_rvalid}, 32'd0);
            check_eq("cancel_after_addr", {20'd0, mem_addr}, 32'd3);
            cyc();
        end
        starve_run(1'b0, 12'd3, 12'd300, 32'h0000_0300);

        // Reset while in V_DATA with a store pending.
        vga_req = 1'b1; vga_addr = 12'd100;
        exp_vga.push_back(32'h0000_00A5);
        cyc();
        reset = 1'b0; vga_req = 1'b0;
        proc_wren = 1'b1; proc_addr = 12'd30; proc_wdata = 32'd99;
        #3;
        check_eq("rst_data_wren", {31'd0, mem_wren}, 32'd0);
        check_eq("rst_data_stall", {31'd0, proc_stall}, 32'd0);
        cyc();
        vga_req = 1'b1;
        #3;
        check_eq("rst_next_rvalid", {31'd0, vga_rvalid}, 32'd0);
        check_eq("rst_next_wren", {31'd0, mem_wren}, 32'd0);
        check_eq("rst_next_stall", {31'd0, proc_stall}, 32'd0);
        cyc();
        reset = 1'b1; vga_req = 1'b0; proc_wren = 1'b0;
        cyc();
        check_eq("rst_store_blocked", mem[30], 32'd0);
        vga_req = 1'b1; vga_addr = 12'd20;
        exp_vga.push_back(32'd42);
        #3;
        check_eq("post_rst_grant_addr", {20'd0, mem_addr}, 32'd20);
        cyc();
        vga_req = 1'b0;
        #3;
        check_eq("post_rst_rvalid", {31'd0, vga_rvalid}, 32'd1);
        cyc();

        // Alternating processor loads with streaming VGA reads 0..9.
        for (int i = 0; i < 10; i++) begin
            mem[i] = 32'h1000 + i;
            mem[50 + i] = 32'h5000 + i;
        end
        n_rvalid = 0;
        vidx = 0; lidx = 0; ld_prev = 1'b0;
        vga_req = 1'b1; vga_addr = 12'd0;
        exp_vga.push_back(32'h1000);
        for (int c = 0; c < 60 && n_rvalid < 10; c++) begin
            if (vga_rvalid) begin
                vidx++;
                if (vidx < 10) begin
                    vga_addr = 12'(vidx);
                    exp_vga.push_back(32'h1000 + 32'(vidx));
                end else begin
                    vga_req = 1'b0;
                end
            end
            proc_rden = (c % 2 == 0);
            proc_addr = 12'(50 + (lidx % 10));
            #3;
            check_eq("stream_stall", {31'd0, proc_stall}, 32'd0);
            if (ld_prev) check_eq("stream_proc_q", proc_q, exp_ld.pop_front());
            ld_prev = proc_rden;
            if (proc_rden) begin
                exp_ld.push_back(32'h5000 + 32'(lidx % 10));
                lidx++;
            end
            cyc();
        end
        proc_rden = 1'b0; vga_req = 1'b0;
        cyc();
        check_eq("stream_rvalid_count", 32'(n_rvalid), 32'd10);
        check_eq("scoreboard_empty", 32'(exp_vga.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
